// File: rtl/slc3_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module : slc3_mem_pkg
// Brief  : Shared types, constants and address decode for the SLC-3 responder.
// Rev    : 1.0
// ============================================================================
package slc3_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      DEC_RAM      = 2'd0,
      DEC_IO       = 2'd1,
      DEC_UNMAPPED = 2'd2
   } decode_t;

   localparam logic [15:0] C_IO_ADDR_DEFAULT = 16'hFFFF;

   // The I/O register wins over RAM so a full 16-bit RAM still exposes it.
   function automatic decode_t f_decode(input logic [15:0] addr,
                                        input int unsigned addr_width,
                                        input logic [15:0] io_addr);
      decode_t dec;
      if (addr == io_addr)
         dec = DEC_IO;
      else if ((addr >> addr_width) == 16'd0)
         dec = DEC_RAM;
      else
         dec = DEC_UNMAPPED;
      return dec;
   endfunction

endpackage
`default_nettype wire

// File: rtl/slc3_ram_sp.sv
`default_nettype none
// ============================================================================
// Module : slc3_ram_sp
// Brief  : Single-port synchronous RAM, one write and one registered read.
// Rev    : 1.0
// ============================================================================
module slc3_ram_sp #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic                  re_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // No reset: contents survive a system reset.
   always_ff @(posedge clk) begin
      if (we_i)
         mem_q[addr_i] <= wdata_i;
      if (re_i)
         rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/slc3_mem_responder.sv
`default_nettype none
// ============================================================================
// Module : slc3_mem_responder
// Brief  : SLC-3 memory/IO responder: RAM, switch/hex I/O, fixed-latency ready.
// Rev    : 1.0
// ============================================================================
module slc3_mem_responder
   import slc3_mem_pkg::*;
#(
   parameter int          ADDR_WIDTH   = 10,
   parameter int          READ_LATENCY = 2,
   parameter logic [15:0] IO_ADDR      = C_IO_ADDR_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [15:0]           mem_addr,
   input  logic [15:0]           mem_wdata,
   input  logic                  mem_mem_ena,
   input  logic                  mem_wr_ena,
   output logic [15:0]           mem_rdata,
   output logic                  mem_ready,
   input  logic [15:0]           sw_i,
   output logic [15:0]           hex_o,
   input  logic                  init_we,
   input  logic [ADDR_WIDTH-1:0] init_addr,
   input  logic [15:0]           init_data,
   output logic                  init_busy
);

   localparam logic [2:0] C_CNT_LOAD = 3'(READ_LATENCY - 1);
   localparam bit         C_SINGLE   = (READ_LATENCY == 1);

   state_t                state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;
   logic [15:0]           addr_q;
   logic                  wr_q;
   logic [15:0]           hex_q;
   logic [15:0]           rdata_q;
   logic [15:0]           sw_meta_q, sw_sync_q;

   logic                  accept;
   logic                  rd_done;
   decode_t               dec_in, dec_q;
   logic                  ram_we, ram_re;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [15:0]           ram_wdata, ram_rdata;
   logic [15:0]           rd_src;

   assign accept  = (state_q == ST_IDLE) && mem_mem_ena;
   assign dec_in  = f_decode(mem_addr, ADDR_WIDTH, IO_ADDR);
   assign dec_q   = f_decode(addr_q, ADDR_WIDTH, IO_ADDR);
   assign rd_done = (state_q == ST_DONE) && !wr_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mem_ready = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mem_mem_ena) begin
               cnt_d   = C_CNT_LOAD;
               state_d = C_SINGLE ? ST_DONE : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 3'd1)
               state_d = ST_DONE;
            else
               cnt_d = cnt_q - 3'd1;
         end
         ST_DONE: begin
            mem_ready = 1'b1;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // The CPU owns the RAM port whenever it is active; init only gets idle cycles.
   always_comb begin
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      ram_addr  = init_addr;
      ram_wdata = init_data;
      if (accept) begin
         ram_addr  = mem_addr[ADDR_WIDTH-1:0];
         ram_wdata = mem_wdata;
         ram_we    = mem_wr_ena && (dec_in == DEC_RAM);
         ram_re    = C_SINGLE && !mem_wr_ena;
      end else if (state_q == ST_IDLE) begin
         ram_we = init_we;
      end else if ((state_q == ST_WAIT) && (cnt_q == 3'd1)) begin
         ram_addr = addr_q[ADDR_WIDTH-1:0];
         ram_re   = !wr_q;
      end
   end

   slc3_ram_sp #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (16)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .re_i    (ram_re),
      .addr_i  (ram_addr),
      .wdata_i (ram_wdata),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q    <= 16'd0;
         wr_q      <= 1'b0;
         hex_q     <= 16'd0;
         rdata_q   <= 16'd0;
         sw_meta_q <= 16'd0;
         sw_sync_q <= 16'd0;
      end else begin
         sw_meta_q <= sw_i;
         sw_sync_q <= sw_meta_q;
         if (accept) begin
            addr_q <= mem_addr;
            wr_q   <= mem_wr_ena;
            if (mem_wr_ena && (dec_in == DEC_IO))
               hex_q <= mem_wdata;
         end
         if (rd_done)
            rdata_q <= rd_src;
      end
   end

   always_comb begin
      case (dec_q)
         DEC_RAM: rd_src = ram_rdata;
         DEC_IO:  rd_src = sw_sync_q;
         default: rd_src = 16'h0000;
      endcase
   end

   // Read data appears as DONE is entered and is then held by rdata_q.
   assign mem_rdata = rd_done ? rd_src : rdata_q;
   assign hex_o     = hex_q;
   assign init_busy = (state_q != ST_IDLE) || mem_mem_ena;

endmodule
`default_nettype wire

// File: tb/tb_slc3_mem_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_slc3_mem_responder
// Brief  : Directed self-checking bench with a transaction-level reference model.
// Rev    : 1.0
// ============================================================================
module tb_slc3_mem_responder;

   localparam int AW  = 10;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [15:0]   mem_addr = '0, mem_wdata = '0;
   logic          mem_mem_ena = 1'b0, mem_wr_ena = 1'b0;
   logic [15:0]   mem_rdata;
   logic          mem_ready;
   logic [15:0]   sw_i = '0;
   logic [15:0]   hex_o;
   logic          init_we = 1'b0;
   logic [AW-1:0] init_addr = '0;
   logic [15:0]   init_data = '0;
   logic          init_busy;

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   slc3_mem_responder #(
      .ADDR_WIDTH   (AW),
      .READ_LATENCY (LAT),
      .IO_ADDR      (16'hFFFF)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_mem_ena (mem_mem_ena),
      .mem_wr_ena  (mem_wr_ena),
      .mem_rdata   (mem_rdata),
      .mem_ready   (mem_ready),
      .sw_i        (sw_i),
      .hex_o       (hex_o),
      .init_we     (init_we),
      .init_addr   (init_addr),
      .init_data   (init_data),
      .init_busy   (init_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference model: each request is a transaction that finishes LAT edges
   // after acceptance; the next one may be accepted one edge after that.
   logic [15:0] m_ram [int];
   int          m_edge = 0, m_next_ok = 0, m_ready_edge = -1;
   logic [15:0] m_pend_addr = '0;
   logic        m_pend_wr = 1'b0;
   logic        m_exp_ready = 1'b0;
   logic [15:0] m_exp_rdata = '0, m_exp_hex = '0;
   logic [15:0] m_meta = '0, m_sync = '0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_edge = 0; m_next_ok = 0; m_ready_edge = -1;
         m_exp_ready = 1'b0; m_exp_rdata = '0; m_exp_hex = '0;
         m_meta = '0; m_sync = '0;
      end else begin
         m_edge++;
         m_sync = m_meta;
         m_meta = sw_i;
         m_exp_ready = 1'b0;
         if (m_edge >= m_next_ok) begin
            if (mem_mem_ena) begin
               m_pend_addr = mem_addr;
               m_pend_wr   = mem_wr_ena;
               if (mem_wr_ena) begin
                  if (mem_addr == 16'hFFFF) m_exp_hex = mem_wdata;
                  else if (mem_addr < 16'd1024) m_ram[int'(mem_addr)] = mem_wdata;
               end
               m_ready_edge = m_edge + LAT - 1;
               m_next_ok    = m_edge + LAT + 1;
            end else if (init_we) begin
               m_ram[int'(init_addr)] = init_data;
            end
         end
         if (m_edge == m_ready_edge) begin
            m_exp_ready = 1'b1;
            if (!m_pend_wr) begin
               if (m_pend_addr == 16'hFFFF) m_exp_rdata = m_sync;
               else if (m_pend_addr < 16'd1024 && m_ram.exists(int'(m_pend_addr)))
                  m_exp_rdata = m_ram[int'(m_pend_addr)];
               else if (m_pend_addr < 16'd1024) m_exp_rdata = 16'hxxxx;
               else m_exp_rdata = 16'h0000;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model.mem_ready", {15'd0, mem_ready}, {15'd0, m_exp_ready});
         check("model.mem_rdata", mem_rdata, m_exp_rdata);
         check("model.hex_o", hex_o, m_exp_hex);
         check("model.init_busy", {15'd0, init_busy},
               {15'd0, ((m_edge + 1 < m_next_ok) || mem_mem_ena)});
      end
   end

   task automatic wait_ready(input string name, output logic [15:0] rd);
      bit seen = 1'b0;
      int lat  = 0;
      rd = 'x;
      for (int j = 1; j <= 10 && !seen; j++) begin
         @(negedge clk);
         if (mem_ready) begin seen = 1'b1; lat = j; rd = mem_rdata; end
      end
      check({name, ".latency"}, 16'(lat), 16'(LAT));
      @(posedge clk); #2;
      @(negedge clk);
      check({name, ".held"}, mem_rdata, rd);
      check({name, ".ready_low"}, {15'd0, mem_ready}, 16'd0);
   endtask

   task automatic access(input logic [15:0] a, input logic [15:0] d, input logic w,
                         input string name, output logic [15:0] rd);
      @(posedge clk); #2;
      mem_addr = a; mem_wdata = d; mem_wr_ena = w; mem_mem_ena = 1'b1;
      @(posedge clk); #2;
      mem_mem_ena = 1'b0;
      mem_addr = 16'h3333; mem_wdata = 16'h4444;
      wait_ready(name, rd);
   endtask

   task automatic init_write(input logic [AW-1:0] a, input logic [15:0] d);
      @(posedge clk); #2;
      init_we = 1'b1; init_addr = a; init_data = d;
      @(negedge clk);
      check("init.busy_low", {15'd0, init_busy}, 16'd0);
      @(posedge clk); #2;
      init_we = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] rd;
      int pulses, first_j, last_j;
      bit gaps_ok;

      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      check("reset.hex_o", hex_o, 16'h0000);
      check("reset.mem_rdata", mem_rdata, 16'h0000);
      check("reset.mem_ready", {15'd0, mem_ready}, 16'd0);

      init_write(10'd5, 16'h1234);
      init_write(10'h3FF, 16'h7777);
      init_write(10'h010, 16'h0000);

      access(16'h0005, 16'h0, 1'b0, "rd5", rd);
      check("rd5.data", rd, 16'h1234);

      access(16'h0010, 16'hBEEF, 1'b1, "wr10", rd);
      access(16'h0010, 16'h0, 1'b0, "rd10", rd);
      check("rd10.data", rd, 16'hBEEF);

      // Held request: expect a ready pulse every LAT+1 cycles.
      @(posedge clk); #2;
      mem_addr = 16'h0010; mem_wr_ena = 1'b0; mem_mem_ena = 1'b1;
      @(posedge clk); #2;
      pulses = 0; first_j = 0; last_j = 0; gaps_ok = 1'b1;
      for (int j = 1; j <= 8; j++) begin
         @(negedge clk);
         if (mem_ready) begin
            if (pulses == 0) first_j = j;
            else if (j - last_j != LAT + 1) gaps_ok = 1'b0;
            last_j = j;
            pulses++;
         end
      end
      @(posedge clk); #2;
      mem_mem_ena = 1'b0;
      check("held.pulses", 16'(pulses), 16'd3);
      check("held.first", 16'(first_j), 16'd2);
      check("held.spacing", {15'd0, gaps_ok}, 16'd1);
      check("held.data", mem_rdata, 16'hBEEF);

      access(16'hFFFF, 16'h00AB, 1'b1, "wrio", rd);
      check("wrio.hex", hex_o, 16'h00AB);
      access(16'h03FF, 16'h0, 1'b0, "rd3ff", rd);
      check("rd3ff.data", rd, 16'h7777);

      sw_i = 16'h5A5A;
      repeat (3) @(posedge clk);
      access(16'hFFFF, 16'h0, 1'b0, "rdio", rd);
      check("rdio.data", rd, 16'h5A5A);

      access(16'h8000, 16'h9999, 1'b1, "wrunm", rd);
      access(16'h8000, 16'h0, 1'b0, "rdunm", rd);
      check("rdunm.data", rd, 16'h0000);

      // Init write colliding with a CPU request must be dropped.
      @(posedge clk); #2;
      mem_addr = 16'h0005; mem_wr_ena = 1'b0; mem_mem_ena = 1'b1;
      init_we = 1'b1; init_addr = 10'd5; init_data = 16'hDEAD;
      @(negedge clk);
      check("coll.busy", {15'd0, init_busy}, 16'd1);
      @(posedge clk); #2;
      mem_mem_ena = 1'b0; init_we = 1'b0;
      wait_ready("coll", rd);
      check("coll.data", rd, 16'h1234);
      access(16'h0005, 16'h0, 1'b0, "reread5", rd);
      check("reread5.data", rd, 16'h1234);

      // Reset while a write transaction sits in WAIT.
      @(posedge clk); #2;
      mem_addr = 16'h0021; mem_wdata = 16'hF00D; mem_wr_ena = 1'b1; mem_mem_ena = 1'b1;
      @(posedge clk); #2;
      mem_mem_ena = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      check("rstwait.ready", {15'd0, mem_ready}, 16'd0);
      check("rstwait.rdata", mem_rdata, 16'h0000);
      check("rstwait.hex", hex_o, 16'h0000);
      @(posedge clk); #2;
      reset = 1'b0;
      pulses = 0;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         if (mem_ready) pulses++;
      end
      check("rstwait.no_ready", 16'(pulses), 16'd0);
      access(16'h0021, 16'h0, 1'b0, "rd21", rd);
      check("rd21.data", rd, 16'hF00D);

      @(posedge clk); #2;
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/slc3_mem_responder.md
Name: slc3_mem_responder

Overview:
Memory/IO responder serving the SLC-3 core's memory initiator port (mem_addr, mem_wdata, mem_mem_ena, mem_wr_ena, mem_rdata).
- Contains on-chip program/data RAM.
- Memory-maps the board switches (read) and a hex-display register (write) at IO_ADDR.
- Adds a fixed-latency completion strobe and a host init port for program loading while the CPU is idle.
- Sits beside cpu in the top level; cpu mem_* outputs drive this block's inputs directly.

Parameters:
- ADDR_WIDTH, 10, RAM depth = 2**ADDR_WIDTH words of 16 bits.
- READ_LATENCY, 2, cycles from request acceptance to mem_ready; legal range 1..7.
- IO_ADDR, 16'hFFFF, address decoded as the switch/hex I/O register.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- mem_addr  in  16  CPU request address (MAR).
- mem_wdata  in  16  CPU write data (MDR).
- mem_mem_ena  in  1  CPU request valid.
- mem_wr_ena  in  1  1 = write, 0 = read; qualified by mem_mem_ena.
- mem_rdata  out  16  read data; valid while mem_ready=1, held afterwards.
- mem_ready  out  1  one-cycle completion strobe.
- sw_i  in  16  board switches, asynchronous.
- hex_o  out  16  hex-display register, written via IO_ADDR.
- init_we  in  1  host program-load write strobe.
- init_addr  in  ADDR_WIDTH  host load address.
- init_data  in  16  host load data.
- init_busy  out  1  1 = init write this cycle will be dropped.

Behaviour:
- Reset: state=IDLE, mem_rdata=0, mem_ready=0, hex_o=0, switch synchronizer=0. RAM contents are not cleared.
- sw_i passes through a 2-flop synchronizer. I/O reads return the synchronized value.
- Decode of a captured address:
  - IO if addr==IO_ADDR.
  - RAM if addr[15:ADDR_WIDTH]==0.
  - Otherwise UNMAPPED: read returns 16'h0000, write dropped.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If mem_mem_ena=1, accept on this edge: capture addr, wdata, wr_ena.
  - Writes commit at the acceptance edge: RAM[addr] or hex_o.
  - Next state is WAIT if READ_LATENCY>1, else DONE.
- WAIT:
  - Counter loads READ_LATENCY-1 at acceptance and decrements each cycle; go to DONE when it reaches 1.
  - RAM read data is registered on the last WAIT cycle. For READ_LATENCY=1 it is registered at the acceptance edge.
- DONE:
  - mem_ready=1 for exactly one cycle. mem_rdata updates on entry to DONE (writes leave it unchanged).
  - Go to IDLE unconditionally.
- Latency: mem_ready is high in cycle k+READ_LATENCY for acceptance at edge k.
- Held mem_mem_ena re-issues the request every READ_LATENCY+1 cycles. This is idempotent for reads; a repeated write rewrites the same data.
- mem_wdata/mem_addr changes after acceptance are ignored until the next acceptance.
- Read-after-write to the same address in back-to-back requests returns the new data (write committed before the read is accepted).
- Init port:
  - init_busy = (state!=IDLE) | mem_mem_ena. The CPU has priority.
  - init_we with init_busy=0 writes RAM[init_addr] at the edge.
  - init_we with init_busy=1 is dropped; nothing is queued.
- Reset mid-operation: the FSM aborts to IDLE and mem_ready is not asserted. A write already committed at acceptance is retained.
- mem_ready is never asserted outside DONE. mem_rdata changes only on entry to DONE or on reset.

Decomposition:
- Package slc3_mem_pkg: state enum type (IDLE, WAIT, DONE), IO_ADDR default constant, address-decode enum (RAM, IO, UNMAPPED).
- Sub-module slc3_ram_sp: single-port synchronous 2**ADDR_WIDTH x 16 RAM, one write port and one registered read.
  - The top level muxes CPU and init accesses onto its single port.
- FSM, latency counter, decode, hex_o register and switch synchronizer live in the top level.

Test Plan:
- Reset then idle: hex_o=0, mem_rdata=0, mem_ready=0. Init writes 16'h1234 to addr 5 with init_busy=0.
- CPU read addr 16'h0005 (READ_LATENCY=2): mem_ready pulses exactly 2 cycles after acceptance, mem_rdata=16'h1234 and held after.
- CPU write 16'hBEEF to 16'h0010, then read 16'h0010: the read returns 16'hBEEF. With mem_mem_ena held, the request repeats every 3 cycles.
- I/O access:
  - Write 16'h00AB to 16'hFFFF: hex_o=16'h00AB, RAM unchanged.
  - Set sw_i=16'h5A5A, wait 3 cycles, read 16'hFFFF: mem_rdata=16'h5A5A.
- Unmapped read of 16'h8000 returns 16'h0000. Init write while mem_mem_ena=1 is dropped: re-read shows the old data.
- Assert reset in the WAIT state: no mem_ready pulse, outputs back to reset values, a previously accepted write is still readable.
